// File: rtl/multicycle_control.sv
// Multicycle control FSM for a MIPS subset, with illegal-op and memory-timeout exceptions.
// Define MULTICYCLE_CONTROL_IRQ_EN to build the interrupt-entry path taken at FETCH entry.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int STATE_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    input  logic               mem_ack,
    input  logic               alu_zero,
    input  logic               irq,
    input  logic               kernel,
    output logic               pc_wr,
    output logic               ir_wr,
    output logic               mem_req,
    output logic               mem_we,
    output logic               reg_wr,
    output logic [2:0]         pc_src,
    output logic [1:0]         reg_dst,
    output logic               alu_src1,
    output logic               alu_src2,
    output logic [5:0]         alu_fun,
    output logic               sign,
    output logic [1:0]         mem_to_reg,
    output logic               ext_op,
    output logic               lu_op,
    output logic [STATE_W-1:0] state
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
        S_WB = 3'd4, S_EXC = 3'd5, S_IRQ = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        K_ALU_R, K_ALU_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_JALR
    } kind_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_cur;
    logic          ld_q, ld_d, ent_q, ent_d, xadr_q, xadr_d, rst_hold_q;

    kind_t         kind;
    logic          legal, dec_src1, dec_src2, dec_sign, dec_ext, dec_lu;
    logic [5:0]    dec_fun, op, fn;
    logic [4:0]    rt;
    logic          irq_take;

    assign op = instruction[31:26];
    assign fn = instruction[5:0];
    assign rt = instruction[20:16];

`ifdef MULTICYCLE_CONTROL_IRQ_EN
    assign irq_take = ent_q & irq & ~kernel;
`else
    logic unused_irq;
    assign unused_irq = irq ^ kernel ^ ent_q;
    assign irq_take   = 1'b0;
`endif
    logic unused_ir;
    assign unused_ir = ^{instruction[25:21], instruction[15:6]};

    assign state = STATE_W'(state_q);

    always_comb begin
        kind = K_ALU_R; legal = 1'b1; dec_fun = 6'b000000;
        dec_src1 = 1'b0; dec_src2 = 1'b0; dec_sign = 1'b1; dec_ext = 1'b1; dec_lu = 1'b0;
        case (op)
            6'h00: case (fn)
                6'h20: ;
                6'h21: dec_sign = 1'b0;
                6'h22: dec_fun = 6'b000001;
                6'h23: begin dec_fun = 6'b000001; dec_sign = 1'b0; end
                6'h24: dec_fun = 6'b011000;
                6'h25: dec_fun = 6'b011110;
                6'h26: dec_fun = 6'b010110;
                6'h27: dec_fun = 6'b010001;
                6'h00: begin dec_fun = 6'b100000; dec_src1 = 1'b1; end
                6'h02: begin dec_fun = 6'b100001; dec_src1 = 1'b1; end
                6'h03: begin dec_fun = 6'b100011; dec_src1 = 1'b1; end
                6'h2a: dec_fun = 6'b110101;
                6'h08: kind = K_JR;
                6'h09: kind = K_JALR;
                default: legal = 1'b0;
            endcase
            6'h23: begin kind = K_LW; dec_src2 = 1'b1; end
            6'h2b: begin kind = K_SW; dec_src2 = 1'b1; end
            6'h0f: begin kind = K_ALU_I; dec_src2 = 1'b1; dec_lu = 1'b1; end
            6'h08: begin kind = K_ALU_I; dec_src2 = 1'b1; end
            6'h09: begin kind = K_ALU_I; dec_src2 = 1'b1; dec_sign = 1'b0; end
            6'h0c: begin kind = K_ALU_I; dec_src2 = 1'b1; dec_fun = 6'b011000; dec_ext = 1'b0; end
            6'h0a: begin kind = K_ALU_I; dec_src2 = 1'b1; dec_fun = 6'b110101; end
            6'h0b: begin kind = K_ALU_I; dec_src2 = 1'b1; dec_fun = 6'b110101; dec_sign = 1'b0; end
            6'h04: begin kind = K_BR; dec_fun = 6'b110011; end
            6'h05: begin kind = K_BR; dec_fun = 6'b110001; end
            6'h06: begin kind = K_BR; dec_fun = 6'b111101; end
            6'h07: begin kind = K_BR; dec_fun = 6'b111111; end
            // REGIMM: only bltz (rt == 0) is implemented
            6'h01: begin kind = K_BR; dec_fun = 6'b111001; legal = (rt == 5'd0); end
            6'h02: kind = K_J;
            6'h03: kind = K_JAL;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        pc_wr = 1'b0; ir_wr = 1'b0; mem_req = 1'b0; mem_we = 1'b0; reg_wr = 1'b0;
        pc_src = 3'b000; reg_dst = 2'b00; mem_to_reg = 2'b00;
        alu_src1 = 1'b0; alu_src2 = 1'b0; alu_fun = 6'b000000;
        sign = 1'b0; ext_op = 1'b0; lu_op = 1'b0;
        state_d = state_q; cnt_d = cnt_q; ld_d = ld_q; ent_d = 1'b0; xadr_d = xadr_q;
        cnt_cur = ld_q ? CW'(MEM_TIMEOUT) : cnt_q;
        // The cycle after a reset edge is held quiet so no request leaks out before release
        if (reset || rst_hold_q) begin
            state_d = S_FETCH; cnt_d = '0; ld_d = 1'b1; xadr_d = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (irq_take) begin
                        state_d = S_IRQ;
                    end else begin
                        mem_req = 1'b1;
                        if (mem_ack) begin
                            ir_wr = 1'b1; pc_wr = 1'b1; state_d = S_DECODE;
                        end else if (cnt_cur == CW'(1)) begin
                            state_d = S_EXC; xadr_d = 1'b1;
                        end else begin
                            cnt_d = cnt_cur - CW'(1); ld_d = 1'b0;
                        end
                    end
                end
                S_DECODE: begin
                    state_d = legal ? S_EXEC : S_EXC;
                    xadr_d  = 1'b0;
                end
                S_EXEC: begin
                    alu_src1 = dec_src1; alu_src2 = dec_src2; alu_fun = dec_fun;
                    sign = dec_sign; ext_op = dec_ext; lu_op = dec_lu;
                    state_d = S_FETCH;
                    case (kind)
                        K_BR:   begin pc_wr = alu_zero; pc_src = 3'b001; end
                        K_J:    begin pc_wr = 1'b1; pc_src = 3'b010; end
                        K_JR:   begin pc_wr = 1'b1; pc_src = 3'b011; end
                        K_JAL:  begin pc_wr = 1'b1; pc_src = 3'b010; reg_wr = 1'b1;
                                      reg_dst = 2'b10; mem_to_reg = 2'b10; end
                        K_JALR: begin pc_wr = 1'b1; pc_src = 3'b011; reg_wr = 1'b1;
                                      reg_dst = 2'b10; mem_to_reg = 2'b10; end
                        K_LW, K_SW: state_d = S_MEM;
                        default: state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (kind == K_SW);
                    if (mem_ack) begin
                        state_d = (kind == K_SW) ? S_FETCH : S_WB;
                    end else if (cnt_cur == CW'(1)) begin
                        state_d = S_EXC; xadr_d = 1'b1;
                    end else begin
                        cnt_d = cnt_cur - CW'(1); ld_d = 1'b0;
                    end
                end
                S_WB: begin
                    reg_wr     = 1'b1;
                    reg_dst    = (kind == K_ALU_R) ? 2'b00 : 2'b01;
                    mem_to_reg = (kind == K_LW) ? 2'b01 : 2'b00;
                    state_d    = S_FETCH;
                end
                S_EXC, S_IRQ: begin
                    reg_wr = 1'b1; reg_dst = 2'b11; mem_to_reg = 2'b10; pc_wr = 1'b1;
                    pc_src = (state_q == S_EXC && xadr_q) ? 3'b101 : 3'b100;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
            if (state_d == S_FETCH && state_q != S_FETCH) begin
                ent_d = 1'b1; ld_d = 1'b1;
            end
            if (state_d == S_MEM && state_q != S_MEM) ld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        rst_hold_q <= reset;
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            ld_q    <= 1'b1;
            ent_q   <= 1'b0;
            xadr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            ent_q   <= ent_d;
            xadr_q  <= xadr_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle state and strobe checks.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        reset, mem_ack, alu_zero, irq, kernel;
    logic [31:0] instruction;
    logic        pc_wr, ir_wr, mem_req, mem_we, reg_wr, alu_src1, alu_src2, sign, ext_op, lu_op;
    logic [2:0]  pc_src, state;
    logic [1:0]  reg_dst, mem_to_reg;
    logic [5:0]  alu_fun;
    logic [4:0]  sb;
    logic [10:0] ctl;
    int          pass_cnt = 0, total = 0;

    localparam logic [31:0] LW    = 32'h8C220004;
    localparam logic [31:0] SW    = 32'hAC220004;
    localparam logic [31:0] BEQ   = 32'h10220010;
    localparam logic [31:0] BNE   = 32'h14220010;
    localparam logic [31:0] JMP   = 32'h08000010;
    localparam logic [31:0] JAL   = 32'h0C000010;
    localparam logic [31:0] JR    = 32'h03E00008;
    localparam logic [31:0] ILL   = 32'hFC000000;
    localparam logic [31:0] SLTU  = 32'h0022182B;

    multicycle_control #(.MEM_TIMEOUT(16), .STATE_W(3)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_ack(mem_ack),
        .alu_zero(alu_zero), .irq(irq), .kernel(kernel), .pc_wr(pc_wr), .ir_wr(ir_wr),
        .mem_req(mem_req), .mem_we(mem_we), .reg_wr(reg_wr), .pc_src(pc_src),
        .reg_dst(reg_dst), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_fun(alu_fun),
        .sign(sign), .mem_to_reg(mem_to_reg), .ext_op(ext_op), .lu_op(lu_op), .state(state)
    );

    always #5 clk = ~clk;
    assign sb  = {pc_wr, ir_wr, mem_req, mem_we, reg_wr};
    assign ctl = {alu_src1, alu_src2, alu_fun, sign, ext_op, lu_op};

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ack(input logic [31:0] ir);
        instruction = ir;
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_ack = 1'b0; alu_zero = 1'b0; irq = 1'b1; kernel = 1'b0;
        instruction = 32'h0;
        cyc(); cyc();
        #1;
        total++; if (sb !== 5'b0) $display("FAIL reset_strobes: got %b want 00000", sb); else pass_cnt++;
        total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else pass_cnt++;
        reset = 1'b0;
        #1;
        total++; if (sb !== 5'b0) $display("FAIL reset_hold_strobes: got %b want 00000", sb); else pass_cnt++;
        cyc();
        #1;
        total++; if (sb !== 5'b00100) $display("FAIL first_fetch_no_irq: got %b want 00100", sb); else pass_cnt++;
        cyc();
        #1;
        total++; if (state !== 3'd0) $display("FAIL first_fetch_state: got %0d want 0", state); else pass_cnt++;
        irq = 1'b0;
        cyc();
    endtask

    task automatic test_lw;
        logic [2:0] exp_st [7];
        logic [4:0] exp_sb [7];
        exp_st = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        exp_sb = '{5'b00100, 5'b00100, 5'b11100, 5'b00000, 5'b00000, 5'b00100, 5'b00001};
        instruction = LW;
        for (int i = 0; i < 7; i++) begin
            mem_ack = (i == 2 || i == 5);
            #1;
            total++; if (state !== exp_st[i] || sb !== exp_sb[i])
                $display("FAIL lw_cycle%0d: got state %0d strobes %b want state %0d strobes %b",
                         i, state, sb, exp_st[i], exp_sb[i]);
            else pass_cnt++;
            if (i == 6) begin
                total++; if (reg_dst !== 2'b01 || mem_to_reg !== 2'b01)
                    $display("FAIL lw_wb_sel: got dst %b m2r %b want 01 01", reg_dst, mem_to_reg);
                else pass_cnt++;
            end
            cyc();
        end
        mem_ack = 1'b0;
        #1;
        total++; if (state !== 3'd0) $display("FAIL lw_return: got %0d want 0", state); else pass_cnt++;
    endtask

    task automatic test_branch_jump;
        fetch_ack(BEQ);
        #1;
        total++; if (state !== 3'd1) $display("FAIL beq_decode: got %0d want 1", state); else pass_cnt++;
        cyc();
        alu_zero = 1'b1;
        #1;
        total++; if (state !== 3'd2 || sb !== 5'b10000 || pc_src !== 3'b001 || alu_fun !== 6'b110011)
            $display("FAIL beq_exec: got st %0d sb %b src %b fun %b want 2 10000 001 110011",
                     state, sb, pc_src, alu_fun);
        else pass_cnt++;
        cyc();
        alu_zero = 1'b0;
        total++; if (state !== 3'd0) $display("FAIL beq_latency: got %0d want 0", state); else pass_cnt++;
        fetch_ack(BNE); cyc();
        #1;
        total++; if (sb !== 5'b00000 || alu_fun !== 6'b110001)
            $display("FAIL bne_exec: got sb %b fun %b want 00000 110001", sb, alu_fun);
        else pass_cnt++;
        cyc();
        fetch_ack(JMP); cyc();
        #1;
        total++; if (sb !== 5'b10000 || pc_src !== 3'b010)
            $display("FAIL j_exec: got sb %b src %b want 10000 010", sb, pc_src);
        else pass_cnt++;
        cyc();
        fetch_ack(JAL); cyc();
        #1;
        total++; if (sb !== 5'b10001 || pc_src !== 3'b010 || reg_dst !== 2'b10 || mem_to_reg !== 2'b10)
            $display("FAIL jal_exec: got sb %b src %b dst %b m2r %b want 10001 010 10 10",
                     sb, pc_src, reg_dst, mem_to_reg);
        else pass_cnt++;
        cyc();
        fetch_ack(JR); cyc();
        #1;
        total++; if (sb !== 5'b10000 || pc_src !== 3'b011)
            $display("FAIL jr_exec: got sb %b src %b want 10000 011", sb, pc_src);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_alu;
        logic [31:0] irs [7];
        logic [10:0] ctls [7];
        logic [1:0]  dsts [7];
        irs  = '{32'h00221820, 32'h00221823, 32'h00021903, 32'h00221827,
                 32'h302200FF, 32'h2C220005, 32'h3C021234};
        ctls = '{11'b0_0_000000_1_1_0, 11'b0_0_000001_0_1_0, 11'b1_0_100011_1_1_0,
                 11'b0_0_010001_1_1_0, 11'b0_1_011000_1_0_0, 11'b0_1_110101_0_1_0,
                 11'b0_1_000000_1_1_1};
        dsts = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        for (int i = 0; i < 7; i++) begin
            fetch_ack(irs[i]); cyc();
            #1;
            total++; if (state !== 3'd2 || sb !== 5'b0 || ctl !== ctls[i])
                $display("FAIL alu%0d_exec: got st %0d sb %b ctl %b want 2 00000 %b",
                         i, state, sb, ctl, ctls[i]);
            else pass_cnt++;
            cyc();
            #1;
            total++; if (state !== 3'd4 || sb !== 5'b00001 || reg_dst !== dsts[i] || mem_to_reg !== 2'b00)
                $display("FAIL alu%0d_wb: got st %0d sb %b dst %b m2r %b want 4 00001 %b 00",
                         i, state, sb, reg_dst, mem_to_reg, dsts[i]);
            else pass_cnt++;
            cyc();
        end
    endtask

    task automatic test_illop;
        logic [31:0] irs [2];
        irs = '{ILL, SLTU};
        for (int i = 0; i < 2; i++) begin
            fetch_ack(irs[i]); cyc();
            #1;
            total++; if (state !== 3'd5 || sb !== 5'b10001 || pc_src !== 3'b100 ||
                         reg_dst !== 2'b11 || mem_to_reg !== 2'b10)
                $display("FAIL illop%0d_exc: got st %0d sb %b src %b dst %b m2r %b want 5 10001 100 11 10",
                         i, state, sb, pc_src, reg_dst, mem_to_reg);
            else pass_cnt++;
            cyc();
            total++; if (state !== 3'd0) $display("FAIL illop%0d_return: got %0d want 0", i, state); else pass_cnt++;
        end
    endtask

    task automatic test_timeout;
        int bad;
        fetch_ack(SW); cyc();
        #1;
        total++; if (ctl !== 11'b0_1_000000_1_1_0) $display("FAIL sw_exec_ctl: got %b want 01000000110", ctl); else pass_cnt++;
        cyc();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (state !== 3'd3 || sb !== 5'b00110) bad++;
            cyc();
        end
        total++; if (bad !== 0) $display("FAIL sw_mem_wait: got %0d bad cycles want 0", bad); else pass_cnt++;
        #1;
        total++; if (state !== 3'd5 || sb !== 5'b10001 || pc_src !== 3'b101)
            $display("FAIL sw_xadr: got st %0d sb %b src %b want 5 10001 101", state, sb, pc_src);
        else pass_cnt++;
        cyc();
        fetch_ack(SW); cyc(); cyc();
        mem_ack = 1'b1;
        #1;
        total++; if (state !== 3'd3 || sb !== 5'b00110) $display("FAIL sw_ack: got st %0d sb %b want 3 00110", state, sb); else pass_cnt++;
        cyc();
        mem_ack = 1'b0;
        total++; if (state !== 3'd0) $display("FAIL sw_latency: got %0d want 0", state); else pass_cnt++;
        instruction = JMP;
        for (int i = 0; i < 15; i++) cyc();
        mem_ack = 1'b1;
        #1;
        total++; if (state !== 3'd0 || sb !== 5'b11100) $display("FAIL fetch_ack_at_expiry: got st %0d sb %b want 0 11100", state, sb); else pass_cnt++;
        cyc();
        mem_ack = 1'b0;
        total++; if (state !== 3'd1) $display("FAIL fetch_expiry_decode: got %0d want 1", state); else pass_cnt++;
        cyc(); cyc();
        for (int i = 0; i < 16; i++) cyc();
        #1;
        total++; if (state !== 3'd5 || pc_src !== 3'b101) $display("FAIL fetch_xadr: got st %0d src %b want 5 101", state, pc_src); else pass_cnt++;
        cyc();
    endtask

    task automatic test_irq;
        irq = 1'b1; kernel = 1'b0;
        #1;
`ifdef MULTICYCLE_CONTROL_IRQ_EN
        total++; if (sb !== 5'b0) $display("FAIL irq_entry_noreq: got %b want 00000", sb); else pass_cnt++;
        cyc();
        irq = 1'b0;
        total++; if (state !== 3'd6 || sb !== 5'b10001 || pc_src !== 3'b100 || reg_dst !== 2'b11)
            $display("FAIL irq_state: got st %0d sb %b src %b dst %b want 6 10001 100 11", state, sb, pc_src, reg_dst);
        else pass_cnt++;
        cyc();
`else
        total++; if (sb !== 5'b00100) $display("FAIL irq_ignored: got %b want 00100", sb); else pass_cnt++;
        fetch_ack(JMP);
        irq = 1'b0;
        cyc(); cyc();
`endif
        irq = 1'b1; kernel = 1'b1;
        #1;
        total++; if (sb !== 5'b00100) $display("FAIL irq_kernel_masked: got %b want 00100", sb); else pass_cnt++;
        fetch_ack(JMP);
        irq = 1'b0; kernel = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset_mid_mem;
        fetch_ack(SW); cyc(); cyc(); cyc();
        reset = 1'b1;
        #1;
        total++; if (state !== 3'd3 || reg_wr !== 1'b0) $display("FAIL rst_mem_cycle2: got st %0d reg_wr %b want 3 0", state, reg_wr); else pass_cnt++;
        cyc();
        total++; if (state !== 3'd0 || sb !== 5'b0) $display("FAIL rst_next_cycle: got st %0d sb %b want 0 00000", state, sb); else pass_cnt++;
        cyc();
        reset = 1'b0;
        #1;
        total++; if (sb !== 5'b0) $display("FAIL rst_release_hold: got %b want 00000", sb); else pass_cnt++;
        cyc();
        total++; if (sb !== 5'b00100) $display("FAIL rst_req_resume: got %b want 00100", sb); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_branch_jump();
        test_alu();
        test_illop();
        test_timeout();
        test_irq();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
